// File: rtl/acia_pkg.sv
// rtl/acia_pkg.sv - shared constants and state encodings for the ACIA transmit path
package acia_pkg;

    localparam int ACIA_BYTE_W = 8;

    typedef enum logic [0:0] {
        TXS_IDLE = 1'b0,
        TXS_ACK  = 1'b1
    } txs_state_t;

endpackage

// File: rtl/acia_tx_fifo.sv
// rtl/acia_tx_fifo.sv - small synchronous byte FIFO with flush
module acia_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two; flush empties in one cycle
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage array carries no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (int'(count) == DEPTH);
    assign empty = (count == '0);

endmodule

// File: rtl/acia_tx_sched.sv
// rtl/acia_tx_sched.sv - round-robin byte scheduler feeding the ACIA transmitter
module acia_tx_sched
    import acia_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                         PHI2,
    input  logic                         RESET,
    input  logic [N_REQ-1:0]             REQ_VALID,
    input  logic [ACIA_BYTE_W*N_REQ-1:0] REQ_DATA,
    output logic [N_REQ-1:0]             REQ_READY,
    input  logic                         FLUSH,
    input  logic                         TXFULL,
    output logic [ACIA_BYTE_W-1:0]       TXDATA,
    output logic                         TXLATCH,
    output logic [$clog2(FIFO_DEPTH):0]  FIFO_COUNT,
    output logic                         BUSY,
    output logic                         ERR_TIMEOUT,
    input  logic                         ERR_CLR
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          grant_idx;
    logic                   grant_any;
    logic [ACIA_BYTE_W-1:0] push_data;

    logic                   fifo_pop;
    logic [ACIA_BYTE_W-1:0] fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;

    txs_state_t             state;
    txs_state_t             state_n;
    logic [TW-1:0]          tmo_cnt;
    logic [TW-1:0]          tmo_cnt_n;
    logic [ACIA_BYTE_W-1:0] txdata_n;
    logic                   txlatch_n;
    logic                   err_set;

    // Requester index `base + k` folded back into 0..N_REQ-1
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    // Round-robin search from rr_ptr; no grant while full, flushing or in reset
    always_comb begin
        REQ_READY = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (!fifo_full && !FLUSH && !RESET) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant_any && REQ_VALID[rr_idx(rr_ptr, k)]) begin
                    grant_any = 1'b1;
                    grant_idx = rr_idx(rr_ptr, k);
                end
            end
            if (grant_any) REQ_READY[grant_idx] = 1'b1;
        end
    end

    assign push_data = REQ_DATA[int'(grant_idx)*ACIA_BYTE_W +: ACIA_BYTE_W];

    // Priority rotates to the requester after the one just served
    always_ff @(posedge PHI2) begin
        if (RESET)
            rr_ptr <= '0;
        else if (grant_any)
            rr_ptr <= rr_idx(grant_idx, 1);
    end

    acia_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ACIA_BYTE_W)
    ) u_fifo (
        .clk   (PHI2),
        .reset (RESET),
        .push  (grant_any),
        .pop   (fifo_pop),
        .flush (FLUSH),
        .din   (push_data),
        .head  (fifo_head),
        .count (FIFO_COUNT),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Launch a byte when the transmitter is free, then wait for it to show TXFULL
    always_comb begin
        state_n   = state;
        txdata_n  = TXDATA;
        txlatch_n = 1'b0;
        tmo_cnt_n = tmo_cnt;
        fifo_pop  = 1'b0;
        err_set   = 1'b0;
        case (state)
            TXS_IDLE: begin
                if (!fifo_empty && !TXFULL && !FLUSH) begin
                    txdata_n  = fifo_head;
                    txlatch_n = 1'b1;
                    fifo_pop  = 1'b1;
                    state_n   = TXS_ACK;
                end
            end
            TXS_ACK: begin
                if (TXFULL) begin
                    state_n   = TXS_IDLE;
                    tmo_cnt_n = '0;
                end else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    err_set   = 1'b1;
                    state_n   = TXS_IDLE;
                    tmo_cnt_n = '0;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            default: state_n = TXS_IDLE;
        endcase
    end

    // FSM state and registered transmitter interface
    always_ff @(posedge PHI2) begin
        if (RESET) begin
            state   <= TXS_IDLE;
            TXDATA  <= '0;
            TXLATCH <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_n;
            TXDATA  <= txdata_n;
            TXLATCH <= txlatch_n;
            tmo_cnt <= tmo_cnt_n;
        end
    end

    // Sticky timeout flag; a new timeout wins over a simultaneous clear
    always_ff @(posedge PHI2) begin
        if (RESET)
            ERR_TIMEOUT <= 1'b0;
        else if (err_set)
            ERR_TIMEOUT <= 1'b1;
        else if (ERR_CLR)
            ERR_TIMEOUT <= 1'b0;
    end

    assign BUSY = !fifo_empty || (state != TXS_IDLE);

endmodule

// File: tb/tb_acia_tx_sched.sv
// tb/tb_acia_tx_sched.sv - directed vectors and corner-case sequences for acia_tx_sched
module tb_acia_tx_sched;

    logic        PHI2 = 1'b0;
    logic        RESET;
    logic [1:0]  REQ_VALID;
    logic [15:0] REQ_DATA;
    logic [1:0]  REQ_READY;
    logic        FLUSH;
    logic        TXFULL;
    logic [7:0]  TXDATA;
    logic        TXLATCH;
    logic [2:0]  FIFO_COUNT;
    logic        BUSY;
    logic        ERR_TIMEOUT;
    logic        ERR_CLR;

    int checks = 0;
    int errors = 0;

    acia_tx_sched #(
        .N_REQ       (2),
        .FIFO_DEPTH  (4),
        .ACK_TIMEOUT (8)
    ) dut (
        .PHI2        (PHI2),
        .RESET       (RESET),
        .REQ_VALID   (REQ_VALID),
        .REQ_DATA    (REQ_DATA),
        .REQ_READY   (REQ_READY),
        .FLUSH       (FLUSH),
        .TXFULL      (TXFULL),
        .TXDATA      (TXDATA),
        .TXLATCH     (TXLATCH),
        .FIFO_COUNT  (FIFO_COUNT),
        .BUSY        (BUSY),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .ERR_CLR     (ERR_CLR)
    );

    always #5 PHI2 = ~PHI2;

    typedef struct {
        logic       rst;
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       txfull;
        logic       flush;
        logic       clr;
        logic [1:0] e_ready;
        logic       e_latch;
        logic [7:0] e_txdata;
        logic [2:0] e_count;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PHI2);
        #1;
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        REQ_VALID = 2'b00;
        REQ_DATA  = 16'h0000;
        FLUSH     = 1'b0;
        TXFULL    = 1'b0;
        ERR_CLR   = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    int         ia, ib, nlat, full_cnt, first_err, nl;
    logic [1:0] fire;
    logic [7:0] got [8];
    logic [7:0] exp_b;

    initial begin
        RESET     = 1'b1;
        REQ_VALID = 2'b00;
        REQ_DATA  = 16'h0000;
        FLUSH     = 1'b0;
        TXFULL    = 1'b0;
        ERR_CLR   = 1'b0;

        //           rst   valid  d0     d1     txf   fl    clr   ready  lat   txdata cnt   busy  err
        vecs[0]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 8'h41, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'h41, 3'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h41, 3'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h41, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'b01, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 8'h41, 3'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 2'b01, 8'hC1, 8'h00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 8'h41, 3'd2, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 2'b01, 8'hC2, 8'h00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 8'h41, 3'd3, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 2'b01, 8'hC3, 8'h00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 8'h41, 3'd4, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 2'b01, 8'hC4, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h41, 3'd4, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 8'hC4, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h41, 3'd4, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 2'b01, 8'hC4, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'hC0, 3'd3, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 2'b01, 8'hC4, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 8'hC0, 3'd4, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'hC0, 3'd4, 1'b1, 1'b0};

        // Reset state, single-byte latency, full FIFO with no push-through
        for (int i = 0; i < NV; i++) begin
            RESET     = vecs[i].rst;
            REQ_VALID = vecs[i].valid;
            REQ_DATA  = {vecs[i].d1, vecs[i].d0};
            TXFULL    = vecs[i].txfull;
            FLUSH     = vecs[i].flush;
            ERR_CLR   = vecs[i].clr;
            #1;
            check($sformatf("v%0d_ready", i), 32'(REQ_READY), 32'(vecs[i].e_ready));
            tick();
            check($sformatf("v%0d_latch", i), 32'(TXLATCH), 32'(vecs[i].e_latch));
            check($sformatf("v%0d_txdata", i), 32'(TXDATA), 32'(vecs[i].e_txdata));
            check($sformatf("v%0d_count", i), 32'(FIFO_COUNT), 32'(vecs[i].e_count));
            check($sformatf("v%0d_busy", i), 32'(BUSY), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_err", i), 32'(ERR_TIMEOUT), 32'(vecs[i].e_err));
        end

        // Two streaming requesters against a transmitter that frees up 10 cycles after each latch
        do_reset();
        ia = 0; ib = 0; nlat = 0; full_cnt = 0;
        for (int cyc = 0; cyc < 400 && nlat < 8; cyc++) begin
            REQ_VALID = {ib < 4, ia < 4};
            REQ_DATA  = {8'(8'hB0 + ib), 8'(8'hA0 + ia)};
            #1;
            fire = REQ_VALID & REQ_READY;
            tick();
            if (fire[0]) ia++;
            if (fire[1]) ib++;
            if (full_cnt > 0) begin
                full_cnt--;
                if (full_cnt == 0) TXFULL = 1'b0;
            end
            if (TXLATCH) begin
                got[nlat] = TXDATA;
                nlat++;
                TXFULL   = 1'b1;
                full_cnt = 10;
            end
        end
        REQ_VALID = 2'b00;
        check("rr_latched_total", 32'(nlat), 32'd8);
        for (int i = 0; i < nlat; i++) begin
            exp_b = (i % 2 == 1) ? 8'(8'hB0 + i / 2) : 8'(8'hA0 + i / 2);
            check($sformatf("rr_order_%0d", i), 32'(got[i]), 32'(exp_b));
        end
        check("rr_err", 32'(ERR_TIMEOUT), 32'd0);

        // Transmitter never raises TXFULL: timeout 8 cycles after the strobe, then clear
        do_reset();
        REQ_VALID = 2'b01;
        REQ_DATA  = 16'h0055;
        tick();
        REQ_VALID = 2'b00;
        tick();
        check("tmo_strobe", 32'(TXLATCH), 32'd1);
        check("tmo_txdata", 32'(TXDATA), 32'h55);
        first_err = 0; nl = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (ERR_TIMEOUT && first_err == 0) first_err = k;
            if (TXLATCH) nl++;
        end
        check("tmo_delay", 32'(first_err), 32'd8);
        check("tmo_relatch", 32'(nl), 32'd0);
        check("tmo_idle_busy", 32'(BUSY), 32'd0);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check("tmo_clear", 32'(ERR_TIMEOUT), 32'd0);

        // Flush with one byte in flight and three queued
        do_reset();
        TXFULL    = 1'b1;
        REQ_VALID = 2'b01;
        for (int i = 0; i < 4; i++) begin
            REQ_DATA = {8'h00, 8'(8'hD0 + i)};
            tick();
        end
        REQ_VALID = 2'b00;
        check("fl_full_count", 32'(FIFO_COUNT), 32'd4);
        TXFULL = 1'b0;
        tick();
        check("fl_launch", 32'(TXLATCH), 32'd1);
        check("fl_count3", 32'(FIFO_COUNT), 32'd3);
        FLUSH     = 1'b1;
        REQ_VALID = 2'b01;
        #1;
        check("fl_ready_blocked", 32'(REQ_READY), 32'd0);
        tick();
        FLUSH     = 1'b0;
        REQ_VALID = 2'b00;
        check("fl_count0", 32'(FIFO_COUNT), 32'd0);
        check("fl_busy_ack", 32'(BUSY), 32'd1);
        TXFULL = 1'b1;
        tick();
        check("fl_busy_done", 32'(BUSY), 32'd0);
        TXFULL = 1'b0;
        nl = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (TXLATCH) nl++;
        end
        check("fl_no_latch", 32'(nl), 32'd0);
        check("fl_count_stays", 32'(FIFO_COUNT), 32'd0);

        // Reset while waiting for acknowledge with two bytes queued
        do_reset();
        TXFULL    = 1'b1;
        REQ_VALID = 2'b01;
        for (int i = 0; i < 3; i++) begin
            REQ_DATA = {8'h00, 8'(8'hE0 + i)};
            tick();
        end
        REQ_VALID = 2'b00;
        TXFULL    = 1'b0;
        tick();
        check("rst_launch", 32'(TXLATCH), 32'd1);
        check("rst_count2", 32'(FIFO_COUNT), 32'd2);
        RESET     = 1'b1;
        REQ_VALID = 2'b11;
        REQ_DATA  = 16'h7766;
        #1;
        check("rst_ready_gated", 32'(REQ_READY), 32'd0);
        tick();
        check("rst_latch", 32'(TXLATCH), 32'd0);
        check("rst_count", 32'(FIFO_COUNT), 32'd0);
        check("rst_err", 32'(ERR_TIMEOUT), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        RESET = 1'b0;
        #1;
        check("rst_rr_req0_first", 32'(REQ_READY), 32'd1);
        tick();
        REQ_VALID = 2'b00;
        check("rst_push_after", 32'(FIFO_COUNT), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
